// File: rtl/pc_sequencer.sv
// Program counter owner for the MIPS core: selects sequential, branch, jump or
// register-jump next PC, optionally deferring redirects by one delay-slot instruction.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DELAY_SLOT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        jump,
  input  logic [25:0] jump_relative_addr,
  input  logic        branch,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump_reg,
  input  logic [31:0] reg_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        redirect_pending,
  output logic        misaligned
);

  localparam logic [0:0] ST_SEQ  = 1'b0;
  localparam logic [0:0] ST_SLOT = 1'b1;

  logic [31:0] pc_r;
  logic [31:0] pending_target_r;
  logic [0:0]  state_r;
  logic        misaligned_r;

  logic        req_s;
  logic        accept_s;
  logic        jr_misaligned_s;
  logic [31:0] target_s;
  logic [31:0] jump_target_s;
  logic [31:0] branch_target_s;
  logic [31:0] jr_target_s;

  assign pc_plus4         = pc_r + 32'd4;
  assign pc               = pc_r;
  assign misaligned       = misaligned_r;
  assign redirect_pending = (state_r == ST_SLOT);

  // Candidate targets and priority selection (jump_reg > jump > taken branch).
  always_comb begin
    jump_target_s   = {pc_plus4[31:28], jump_relative_addr, 2'b00};
    branch_target_s = pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
    jr_target_s     = {reg_target[31:2], 2'b00};
    req_s           = 1'b0;
    target_s        = pc_plus4;
    if (jump_reg) begin
      req_s    = 1'b1;
      target_s = jr_target_s;
    end else if (jump) begin
      req_s    = 1'b1;
      target_s = jump_target_s;
    end else if (branch && branch_taken) begin
      req_s    = 1'b1;
      target_s = branch_target_s;
    end else begin
      req_s    = 1'b0;
      target_s = pc_plus4;
    end
  end

  // Requests are only honoured in SEQ; a branch sitting in the delay slot is dropped.
  assign accept_s        = !stall && (state_r == ST_SEQ) && req_s;
  assign jr_misaligned_s = accept_s && jump_reg && (reg_target[1:0] != 2'b00);

  // PC, pending-target and delay-slot FSM state update.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r             <= RESET_PC;
      pending_target_r <= 32'h0000_0000;
      state_r          <= ST_SEQ;
      misaligned_r     <= 1'b0;
    end else if (!stall) begin
      misaligned_r <= jr_misaligned_s;
      case (state_r)
        ST_SEQ: begin
          if (accept_s && (DELAY_SLOT != 0)) begin
            pc_r             <= pc_plus4;
            pending_target_r <= target_s;
            state_r          <= ST_SLOT;
          end else if (accept_s) begin
            pc_r    <= target_s;
            state_r <= ST_SEQ;
          end else begin
            pc_r    <= pc_plus4;
            state_r <= ST_SEQ;
          end
        end
        ST_SLOT: begin
          pc_r    <= pending_target_r;
          state_r <= ST_SEQ;
        end
        default: begin
          pc_r    <= pc_plus4;
          state_r <= ST_SEQ;
        end
      endcase
    end else begin
      pc_r             <= pc_r;
      pending_target_r <= pending_target_r;
      state_r          <= state_r;
      misaligned_r     <= misaligned_r;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: one instance without and one with delay slot,
// driven by shared stimulus and checked against hand-computed PC values.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        jump;
  logic [25:0] jump_relative_addr;
  logic        branch;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump_reg;
  logic [31:0] reg_target;

  logic [31:0] pc0, pc_plus4_0, pc1, pc_plus4_1;
  logic        rp0, mis0, rp1, mis1;

  int n_checks = 0;
  int n_errors = 0;

  pc_sequencer #(.RESET_PC(32'h0000_0000), .DELAY_SLOT(0)) u_dut0 (
    .clk(clk), .reset(reset), .stall(stall), .jump(jump),
    .jump_relative_addr(jump_relative_addr), .branch(branch),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump_reg(jump_reg), .reg_target(reg_target), .pc(pc0),
    .pc_plus4(pc_plus4_0), .redirect_pending(rp0), .misaligned(mis0)
  );

  pc_sequencer #(.RESET_PC(32'h0000_0000), .DELAY_SLOT(1)) u_dut1 (
    .clk(clk), .reset(reset), .stall(stall), .jump(jump),
    .jump_relative_addr(jump_relative_addr), .branch(branch),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump_reg(jump_reg), .reg_target(reg_target), .pc(pc1),
    .pc_plus4(pc_plus4_1), .redirect_pending(rp1), .misaligned(mis1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 1'b0; jump = 1'b0; jump_relative_addr = 26'h0;
    branch = 1'b0; branch_taken = 1'b0; branch_offset = 16'h0;
    jump_reg = 1'b0; reg_target = 32'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();

    // 1. reset and sequential fetch with one stall cycle at 0x8
    do_reset();
    check_eq("t1_reset_pc0", pc0, 32'h0);
    check_eq("t1_reset_pc1", pc1, 32'h0);
    check_eq("t1_reset_rp1", {31'd0, rp1}, 32'h0);
    check_eq("t1_reset_mis0", {31'd0, mis0}, 32'h0);
    step(); check_eq("t1_pc_4", pc0, 32'h4);
    step(); check_eq("t1_pc_8", pc0, 32'h8);
    stall = 1'b1;
    step(); check_eq("t1_stall_hold0", pc0, 32'h8);
    check_eq("t1_stall_hold1", pc1, 32'h8);
    stall = 1'b0;
    step(); check_eq("t1_pc_c", pc0, 32'hC);
    check_eq("t1_pc_plus4", pc_plus4_0, 32'h10);

    // 2. jump at 0x8, both delay-slot modes
    do_reset();
    step(); step();
    check_eq("t2_at_8", pc1, 32'h8);
    jump = 1'b1; jump_relative_addr = 26'h1;
    step();
    clear_inputs();
    check_eq("t2_ds0_pc", pc0, 32'h4);
    check_eq("t2_ds0_rp", {31'd0, rp0}, 32'h0);
    check_eq("t2_ds1_slot_pc", pc1, 32'hC);
    check_eq("t2_ds1_rp_hi", {31'd0, rp1}, 32'h1);
    step();
    check_eq("t2_ds1_pc", pc1, 32'h4);
    check_eq("t2_ds1_rp_lo", {31'd0, rp1}, 32'h0);

    // 3. region-preserving jump to top of memory and wrap (DELAY_SLOT=0)
    do_reset();
    jump_reg = 1'b1; reg_target = 32'hF000_0000;
    step();
    clear_inputs();
    check_eq("t3_jr", pc0, 32'hF000_0000);
    jump = 1'b1; jump_relative_addr = 26'h3FF_FFFF;
    step();
    clear_inputs();
    check_eq("t3_jump_top", pc0, 32'hFFFF_FFFC);
    step();
    check_eq("t3_wrap", pc0, 32'h0);
    branch = 1'b1; branch_taken = 1'b1; branch_offset = 16'hFFFE;
    step();
    clear_inputs();
    check_eq("t3_back_wrap", pc0, 32'hFFFF_FFFC);

    // 4. branches at 0x100 (DELAY_SLOT=0)
    do_reset();
    jump_reg = 1'b1; reg_target = 32'h100;
    step();
    clear_inputs();
    check_eq("t4_at_100", pc0, 32'h100);
    branch = 1'b1; branch_taken = 1'b1; branch_offset = 16'hFFFF;
    step();
    check_eq("t4_self_loop", pc0, 32'h100);
    branch_offset = 16'h0002;
    step();
    check_eq("t4_fwd", pc0, 32'h10C);
    clear_inputs();
    jump_reg = 1'b1; reg_target = 32'h100;
    step();
    clear_inputs();
    branch = 1'b1; branch_taken = 1'b0; branch_offset = 16'h0002;
    step();
    clear_inputs();
    check_eq("t4_not_taken", pc0, 32'h104);

    // 5. priority, misaligned flag, branch in delay slot ignored
    do_reset();
    jump_reg = 1'b1; reg_target = 32'h0040_0003;
    jump = 1'b1; jump_relative_addr = 26'h10;
    branch = 1'b1; branch_taken = 1'b1; branch_offset = 16'h0020;
    step();
    clear_inputs();
    check_eq("t5_prio_pc0", pc0, 32'h0040_0000);
    check_eq("t5_mis0_hi", {31'd0, mis0}, 32'h1);
    check_eq("t5_ds1_slot", pc1, 32'h4);
    check_eq("t5_mis1_hi", {31'd0, mis1}, 32'h1);
    branch = 1'b1; branch_taken = 1'b1; branch_offset = 16'h0010;
    step();
    clear_inputs();
    check_eq("t5_mis0_lo", {31'd0, mis0}, 32'h0);
    check_eq("t5_ds0_branch", pc0, 32'h0040_0044);
    check_eq("t5_ds1_redirect", pc1, 32'h0040_0000);
    check_eq("t5_mis1_lo", {31'd0, mis1}, 32'h0);
    step();
    check_eq("t5_ds1_slot_branch_ignored", pc1, 32'h0040_0004);

    // 6. reset while stalled in SLOT drops the pending target
    do_reset();
    jump = 1'b1; jump_relative_addr = 26'h40;
    step();
    clear_inputs();
    check_eq("t6_slot_pc", pc1, 32'h4);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t6_stall_pc", pc1, 32'h4);
      check_eq("t6_stall_rp", {31'd0, rp1}, 32'h1);
    end
    reset = 1'b1;
    step();
    reset = 1'b0; stall = 1'b0;
    check_eq("t6_reset_pc", pc1, 32'h0);
    check_eq("t6_reset_rp", {31'd0, rp1}, 32'h0);
    step();
    check_eq("t6_no_pending_pc", pc1, 32'h4);
    check_eq("t6_no_pending_rp", {31'd0, rp1}, 32'h0);
    step();
    check_eq("t6_seq_pc", pc1, 32'h8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
